game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer_pkg.sv | 22 ++
 rtl/game_sequencer_countdown.sv | 38 +++
 rtl/game_sequencer.sv | 146 ++++++++++++++
 tb/tb_game_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer.
// State encodings, parameter defaults and a score helper.
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ATTRACT = 2'b00,
    ST_PLAY    = 2'b01,
    ST_HIT     = 2'b10,
    ST_OVER    = 2'b11
  } state_e;

  localparam int unsigned DEF_START_LIVES = 3;
  localparam int unsigned DEF_HIT_FRAMES  = 60;
  localparam int unsigned DEF_OVER_FRAMES = 120;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_sequencer_countdown.sv
// Loadable 8-bit frame down-counter.
// Stops at zero; load wins over the frame decrement.
module frame_countdown (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_end_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] next_o,
  output logic       is_one_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // next count: load, else step down once per frame
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (frame_end_i && count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign next_o   = count_d;
  assign is_one_o = (count_q == 8'd1);

endmodule

// File: rtl/game_sequencer.sv
// Game flow sequencer: attract, play, hit, game over.
// Updates on frame boundaries; all outputs are registered.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned START_LIVES = DEF_START_LIVES,
  parameter int unsigned HIT_FRAMES  = DEF_HIT_FRAMES,
  parameter int unsigned OVER_FRAMES = DEF_OVER_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_end,
  input  logic       start,
  input  logic       collision,
  input  logic       dragon_hit,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_enable,
  output logic       flash,
  output logic       entity_reset
);

  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [7:0] HIT_LD     = 8'(HIT_FRAMES);
  localparam logic [7:0] OVER_LD    = 8'(OVER_FRAMES);

  state_e     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] score_q, score_d;
  logic       pend_q, pend_d;
  logic       start_q, start_d;
  logic       ge_q, ge_d;
  logic       flash_q, flash_d;
  logic       er_q, er_d;

  logic       cnt_load;
  logic [7:0] cnt_val;
  logic [7:0] cnt_next;
  logic       cnt_one;

  frame_countdown u_timer (
    .clk_i       (clk),
    .reset_i     (reset),
    .frame_end_i (frame_end),
    .load_i      (cnt_load),
    .load_val_i  (cnt_val),
    .next_o      (cnt_next),
    .is_one_o    (cnt_one)
  );

  // frame-boundary FSM, score, lives and hit-pending logic
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    score_d  = score_q;
    start_d  = start_q;
    pend_d   = pend_q | dragon_hit;
    er_d     = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = 8'd0;
    if (frame_end) begin
      start_d = start;
      pend_d  = dragon_hit;
      unique case (state_q)
        ST_ATTRACT: begin
          if (start && !start_q) begin
            state_d = ST_PLAY;
            lives_d = LIVES_INIT;
            score_d = 8'd0;
            er_d    = 1'b1;
          end
        end
        ST_PLAY: begin
          if (collision) begin
            cnt_load = 1'b1;
            if (lives_q > 2'd1) begin
              lives_d = lives_q - 2'd1;
              cnt_val = HIT_LD;
              state_d = ST_HIT;
            end else begin
              lives_d = 2'd0;
              cnt_val = OVER_LD;
              state_d = ST_OVER;
            end
          end else if (pend_q) begin
            score_d = sat_inc(score_q);
          end
        end
        ST_HIT: begin
          if (cnt_one) begin
            state_d = ST_PLAY;
            er_d    = 1'b1;
          end
        end
        ST_OVER: begin
          if (cnt_one) begin
            state_d = ST_ATTRACT;
          end
        end
      endcase
    end
  end

  // output flags derived from the upcoming state
  always_comb begin
    ge_d    = (state_d == ST_PLAY);
    flash_d = 1'b0;
    if (state_d == ST_HIT) begin
      flash_d = cnt_next[3];
    end else if (state_d == ST_OVER) begin
      flash_d = 1'b1;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ATTRACT;
      lives_q <= LIVES_INIT;
      score_q <= 8'd0;
      pend_q  <= 1'b0;
      start_q <= 1'b1;
      ge_q    <= 1'b0;
      flash_q <= 1'b0;
      er_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      score_q <= score_d;
      pend_q  <= pend_d;
      start_q <= start_d;
      ge_q    <= ge_d;
      flash_q <= flash_d;
      er_q    <= er_d;
    end
  end

  assign state        = state_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign game_enable  = ge_q;
  assign flash        = flash_q;
  assign entity_reset = er_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer.
// Expected frame results are queued and checked after each frame.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_end = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       dragon_hit = 1'b0;
  logic [1:0] state;
  logic [1:0] lives;
  logic [7:0] score;
  logic       game_enable;
  logic       flash;
  logic       entity_reset;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] lv;
    logic [7:0] sc;
    logic       ge;
    logic       fl;
    logic       er;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t mon_a;
  int   errors = 0;
  int   checks = 0;
  logic fe_seen = 1'b0;

  always #5 clk = ~clk;

  game_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .frame_end    (frame_end),
    .start        (start),
    .collision    (collision),
    .dragon_hit   (dragon_hit),
    .state        (state),
    .lives        (lives),
    .score        (score),
    .game_enable  (game_enable),
    .flash        (flash),
    .entity_reset (entity_reset)
  );

  always @(posedge clk) fe_seen <= frame_end && !reset;

  always @(negedge clk) begin
    if (fe_seen) begin
      mon_a = {state, lives, score, game_enable, flash, entity_reset};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got %h, no expectation queued", mon_a);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL frame: got st=%0d lv=%0d sc=%0d ge=%0b fl=%0b er=%0b want st=%0d lv=%0d sc=%0d ge=%0b fl=%0b er=%0b",
            mon_a.st, mon_a.lv, mon_a.sc, mon_a.ge, mon_a.fl, mon_a.er,
            mon_e.st, mon_e.lv, mon_e.sc, mon_e.ge, mon_e.fl, mon_e.er);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic fexp(input logic hit, input logic [1:0] st,
                      input logic [1:0] lv, input logic [7:0] sc,
                      input logic ge, input logic fl, input logic er);
    sb_q.push_back({st, lv, sc, ge, fl, er});
    @(negedge clk);
    frame_end  = 1'b1;
    dragon_hit = hit;
    @(negedge clk);
    frame_end  = 1'b0;
    dragon_hit = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge clk);
    dragon_hit = 1'b1;
    @(negedge clk);
    dragon_hit = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, lives, score, game_enable, flash, entity_reset} !==
        {ST_ATTRACT, 2'd3, 8'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: got st=%0d lv=%0d sc=%0d ge=%0b fl=%0b er=%0b want 0 3 0 0 0 0",
        state, lives, score, game_enable, flash, entity_reset);
    end
    reset = 1'b0;
  endtask

  task automatic test_start();
    repeat (3) fexp(0, ST_ATTRACT, 2'd3, 8'd0, 0, 0, 0);
    start = 1'b0;
    fexp(0, ST_ATTRACT, 2'd3, 8'd0, 0, 0, 0);
    start = 1'b1;
    fexp(0, ST_PLAY, 2'd3, 8'd0, 1, 0, 1);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (entity_reset !== 1'b0 || state !== ST_PLAY) begin
      errors++;
      $display("FAIL start_er_pulse: got er=%0b st=%0d want er=0 st=1", entity_reset, state);
    end
  endtask

  task automatic test_score();
    for (int i = 1; i <= 5; i++) begin
      pulse_hit();
      fexp(0, ST_PLAY, 2'd3, 8'(i), 1, 0, 0);
    end
    pulse_hit();
    pulse_hit();
    fexp(0, ST_PLAY, 2'd3, 8'd6, 1, 0, 0);
    fexp(0, ST_PLAY, 2'd3, 8'd6, 1, 0, 0);
  endtask

  task automatic run_hit(input logic [1:0] lv, input logic [7:0] sc);
    logic [7:0] t;
    collision = 1'b1;
    fexp(0, ST_HIT, lv, sc, 0, 1, 0);
    for (int k = 1; k <= 59; k++) begin
      t = 8'(60 - k);
      fexp(0, ST_HIT, lv, sc, 0, t[3], 0);
    end
    fexp(0, ST_PLAY, lv, sc, 1, 0, 1);
    collision = 1'b0;
    @(negedge clk);
    checks++;
    if (entity_reset !== 1'b0 || game_enable !== 1'b1) begin
      errors++;
      $display("FAIL hit_er_pulse: got er=%0b ge=%0b want er=0 ge=1", entity_reset, game_enable);
    end
  endtask

  task automatic test_hit();
    run_hit(2'd2, 8'd6);
  endtask

  task automatic test_game_over();
    run_hit(2'd1, 8'd6);
    pulse_hit();
    collision = 1'b1;
    fexp(1, ST_OVER, 2'd0, 8'd6, 0, 1, 0);
    collision = 1'b0;
    for (int k = 1; k <= 119; k++) begin
      if (k == 50) start = 1'b1;
      if (k == 60) start = 1'b0;
      fexp(0, ST_OVER, 2'd0, 8'd6, 0, 1, 0);
    end
    fexp(0, ST_ATTRACT, 2'd0, 8'd6, 0, 0, 0);
    fexp(0, ST_ATTRACT, 2'd0, 8'd6, 0, 0, 0);
  endtask

  task automatic test_saturate();
    start = 1'b1;
    fexp(0, ST_PLAY, 2'd3, 8'd0, 1, 0, 1);
    start = 1'b0;
    fexp(1, ST_PLAY, 2'd3, 8'd0, 1, 0, 0);
    for (int k = 1; k <= 254; k++) begin
      fexp(1, ST_PLAY, 2'd3, 8'(k), 1, 0, 0);
    end
    fexp(1, ST_PLAY, 2'd3, 8'd255, 1, 0, 0);
    fexp(1, ST_PLAY, 2'd3, 8'd255, 1, 0, 0);
    fexp(0, ST_PLAY, 2'd3, 8'd255, 1, 0, 0);
    fexp(0, ST_PLAY, 2'd3, 8'd255, 1, 0, 0);
  endtask

  task automatic test_reset_mid_hit();
    logic [7:0] t;
    collision = 1'b1;
    fexp(0, ST_HIT, 2'd2, 8'd255, 0, 1, 0);
    for (int k = 1; k <= 29; k++) begin
      t = 8'(60 - k);
      fexp(0, ST_HIT, 2'd2, 8'd255, 0, t[3], 0);
    end
    @(negedge clk);
    reset      = 1'b1;
    frame_end  = 1'b1;
    start      = 1'b1;
    dragon_hit = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    frame_end  = 1'b0;
    dragon_hit = 1'b0;
    collision  = 1'b0;
    checks++;
    if ({state, lives, score, game_enable, flash, entity_reset} !==
        {ST_ATTRACT, 2'd3, 8'd0, 3'b000} ||
        dut.u_timer.count_q !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_hit: got st=%0d lv=%0d sc=%0d ge=%0b fl=%0b er=%0b tmr=%0d want 0 3 0 0 0 0 0",
        state, lives, score, game_enable, flash, entity_reset, dut.u_timer.count_q);
    end
    fexp(0, ST_ATTRACT, 2'd3, 8'd0, 0, 0, 0);
    fexp(0, ST_ATTRACT, 2'd3, 8'd0, 0, 0, 0);
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_score();
    test_hit();
    test_game_over();
    test_saturate();
    test_reset_mid_hit();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
